// File: rtl/score_pkg.sv
// Shared types and constants for the Pong score keeper and score-area pixel mapper.
//   state_e   : game FSM states (PLAY, WIN_L, WIN_R)
//   box_e     : which of the four digit boxes a pixel falls in
//   BLANK     : digit code that makes the glyph ROM output nothing
//   GLYPH_*   : glyph geometry of the 3x5 ROM font
//   bcd_value : converts a 2-digit BCD score to binary for the win compare
package score_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WIN_L = 2'd1,
        WIN_R = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BOX_L_TENS  = 2'd0,
        BOX_L_UNITS = 2'd1,
        BOX_R_TENS  = 2'd2,
        BOX_R_UNITS = 2'd3
    } box_e;

    localparam logic [4:0] BLANK = 5'd31;

    localparam int unsigned GLYPH_W    = 3;
    localparam int unsigned GLYPH_H    = 5;
    localparam int unsigned GLYPH_BITS = 15;

    localparam int unsigned SCORE_W = 7;

    // Binary value of a BCD pair; 99 max fits in 7 bits.
    function automatic logic [SCORE_W-1:0] bcd_value(input logic [3:0] tens,
                                                     input logic [3:0] units);
        return SCORE_W'(tens) * SCORE_W'(10) + SCORE_W'(units);
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD up-counter for one player's score.
//   clk, reset : pixel clock, async active-high reset
//   inc        : count one goal
//   clr        : clear to 00 (wins over inc)
//   tens/units : current BCD digits
module bcd_counter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;

    // Units roll 9 -> 0 and carry into tens; tens wrap 9 -> 0.
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (inc) begin
            if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;

endmodule

// File: rtl/score_board.sv
// Two-player score keeper plus score-area pixel mapper for the Pong VGA path.
//   clk, reset            : pixel clock, async active-high reset
//   pixel_x/y, video_on   : current raster position and active-video flag
//   frame_tick            : once-per-frame pulse driving the win blink
//   goal_left/right       : one-cycle goal pulses
//   new_game              : one-cycle pulse clearing both scores
//   number, position      : registered address to the external 3x5 glyph ROM
//   glyph_pixel           : combinational ROM reply
//   score_pixel           : registered score pixel, 3 cycles after pixel_x/y
//   game_over, winner     : registered win status
module score_board
    import score_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned X_LEFT      = 240,
    parameter int unsigned X_RIGHT     = 352,
    parameter int unsigned Y_TOP       = 16,
    parameter int unsigned SCALE_SHIFT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       frame_tick,
    input  logic       goal_left,
    input  logic       goal_right,
    input  logic       new_game,
    output logic [4:0] number,
    output logic [4:0] position,
    input  logic       glyph_pixel,
    output logic       score_pixel,
    output logic       game_over,
    output logic       winner
);

    localparam int unsigned CELL     = 1 << SCALE_SHIFT;
    localparam int unsigned BOX_W    = GLYPH_W * CELL;
    localparam int unsigned BOX_H    = GLYPH_H * CELL;
    localparam int unsigned UNIT_OFS = (GLYPH_W + 1) * CELL;

    localparam logic [9:0] LT_X    = 10'(X_LEFT);
    localparam logic [9:0] LU_X    = 10'(X_LEFT + UNIT_OFS);
    localparam logic [9:0] RT_X    = 10'(X_RIGHT);
    localparam logic [9:0] RU_X    = 10'(X_RIGHT + UNIT_OFS);
    localparam logic [9:0] TOP_Y   = 10'(Y_TOP);
    localparam logic [9:0] BOT_Y   = 10'(Y_TOP + BOX_H);
    localparam logic [9:0] BOX_W10 = 10'(BOX_W);

    // ---------------- score counters and game FSM ----------------
    logic [3:0]         l_tens, l_units, r_tens, r_units;
    logic               inc_l, inc_r, win_l, win_r;
    logic [SCORE_W-1:0] l_val, r_val;

    state_e     state_q, state_d;
    logic [5:0] blink_q, blink_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;

    assign inc_l = goal_left  && (state_q == PLAY) && !new_game;
    assign inc_r = goal_right && (state_q == PLAY) && !new_game;

    bcd_counter2 u_left (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_l),
        .clr   (new_game),
        .tens  (l_tens),
        .units (l_units)
    );

    bcd_counter2 u_right (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_r),
        .clr   (new_game),
        .tens  (r_tens),
        .units (r_units)
    );

    assign l_val = bcd_value(l_tens, l_units);
    assign r_val = bcd_value(r_tens, r_units);

    // Win is judged on the post-increment value so the FSM moves on the same edge as the counter.
    assign win_l = inc_l && ((l_val + SCORE_W'(1)) == SCORE_W'(WIN_SCORE));
    assign win_r = inc_r && ((r_val + SCORE_W'(1)) == SCORE_W'(WIN_SCORE));

    // Next state, blink counter and win status.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PLAY: begin
                if (win_l) begin
                    state_d = WIN_L;
                end else if (win_r) begin
                    state_d = WIN_R;
                end
            end
            WIN_L, WIN_R: state_d = state_q;
            default:      state_d = PLAY;
        endcase
        if (new_game) begin
            state_d = PLAY;
        end

        blink_d = blink_q;
        if ((state_q == PLAY) && (state_d != PLAY)) begin
            blink_d = 6'd0;
        end else if (frame_tick) begin
            blink_d = blink_q + 6'd1;
        end

        game_over_d = (state_d != PLAY);
        winner_d    = (state_d == WIN_R);
    end

    // ---------------- render pipeline ----------------
    logic       hit_q, hit_d;
    box_e       box_q, box_d;
    logic [2:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic       von_q;
    logic [9:0] box_x, dx, dy;
    logic       in_rows;

    assign in_rows = (pixel_y >= TOP_Y) && (pixel_y < BOT_Y);

    // Stage 1: locate the pixel in one of the four digit boxes.
    always_comb begin
        hit_d = 1'b0;
        box_d = BOX_L_TENS;
        box_x = LT_X;
        if (in_rows) begin
            if ((pixel_x >= LT_X) && (pixel_x < LT_X + BOX_W10)) begin
                hit_d = 1'b1;
                box_d = BOX_L_TENS;
                box_x = LT_X;
            end else if ((pixel_x >= LU_X) && (pixel_x < LU_X + BOX_W10)) begin
                hit_d = 1'b1;
                box_d = BOX_L_UNITS;
                box_x = LU_X;
            end else if ((pixel_x >= RT_X) && (pixel_x < RT_X + BOX_W10)) begin
                hit_d = 1'b1;
                box_d = BOX_R_TENS;
                box_x = RT_X;
            end else if ((pixel_x >= RU_X) && (pixel_x < RU_X + BOX_W10)) begin
                hit_d = 1'b1;
                box_d = BOX_R_UNITS;
                box_x = RU_X;
            end
        end
        dx    = pixel_x - box_x;
        dy    = pixel_y - TOP_Y;
        col_d = 2'(dx >> SCALE_SHIFT);
        row_d = 3'(dy >> SCALE_SHIFT);
    end

    logic [4:0] number_q, number_d;
    logic [4:0] position_q, position_d;
    logic [3:0] digit;
    logic       is_tens, is_right, hide;

    // Stage 2: pick the digit, apply leading-zero and blink blanking, form the ROM bit index.
    always_comb begin
        digit    = 4'd0;
        is_tens  = 1'b0;
        is_right = 1'b0;
        case (box_q)
            BOX_L_TENS:  begin digit = l_tens;  is_tens = 1'b1; end
            BOX_L_UNITS: begin digit = l_units;                 end
            BOX_R_TENS:  begin digit = r_tens;  is_tens = 1'b1; is_right = 1'b1; end
            BOX_R_UNITS: begin digit = r_units; is_right = 1'b1; end
        endcase

        hide = blink_q[5] && (((state_q == WIN_L) && !is_right) ||
                              ((state_q == WIN_R) &&  is_right));

        number_d   = BLANK;
        position_d = 5'd0;
        if (von_q && hit_q && !hide && !(is_tens && (digit == 4'd0))) begin
            number_d   = {1'b0, digit};
            position_d = 5'(GLYPH_BITS - 1) - 5'(GLYPH_W) * {2'b00, row_q} - {3'b000, col_q};
        end
    end

    logic score_pixel_q, score_pixel_d;

    // Stage 3: gate the ROM reply so a blank code never lights a pixel.
    assign score_pixel_d = glyph_pixel && (number_q != BLANK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= PLAY;
            blink_q       <= 6'd0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            hit_q         <= 1'b0;
            box_q         <= BOX_L_TENS;
            row_q         <= 3'd0;
            col_q         <= 2'd0;
            von_q         <= 1'b0;
            number_q      <= BLANK;
            position_q    <= 5'd0;
            score_pixel_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            blink_q       <= blink_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            hit_q         <= hit_d;
            box_q         <= box_d;
            row_q         <= row_d;
            col_q         <= col_d;
            von_q         <= video_on;
            number_q      <= number_d;
            position_q    <= position_d;
            score_pixel_q <= score_pixel_d;
        end
    end

    assign number      = number_q;
    assign position    = position_q;
    assign score_pixel = score_pixel_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule
